// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and pipeline response type for the dmem MMIO responder
package mmio_pkg;
    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'h8000;
    localparam logic [2:0] MMIO_LED = 3'd0;
    localparam logic [2:0] MMIO_CON_TX = 3'd1;
    localparam logic [2:0] MMIO_CYCLE_LO = 3'd2;
    localparam logic [2:0] MMIO_CYCLE_HI = 3'd3;
    localparam logic [2:0] MMIO_DROPPED = 3'd4;
    typedef struct packed {
        logic is_mmio;
        logic [31:0] rdata;
    } mmio_rsp_t;
endpackage

// File: rtl/console_fifo.sv
// console_fifo: circular byte FIFO with valid/ready drain; empty head reads as zero
module console_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic pop, do_push;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = !empty;
    assign pop = valid && ready;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign do_push = push && (!full || pop);
    assign dout = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (pop) rd_ptr <= rd_ptr + ONE;
        end
    end
    always_ff @(posedge clk_in) begin
        if (do_push && !rst_in) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: routes core data accesses to BRAM or an MMIO bank with matched 2-cycle read latency
module dmem_mmio_responder import mmio_pkg::*; #(
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int CON_DEPTH = 16,
    parameter int LED_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [31:0]          dmem_addr_in,
    input  logic [31:0]          dmem_data_in,
    input  logic [3:0]           dmem_write_enable_in,
    output logic [31:0]          dmem_data_out,
    output logic [31:0]          ram_addr_out,
    output logic [31:0]          ram_data_out,
    output logic [3:0]           ram_write_enable_out,
    input  logic [31:0]          ram_data_in,
    output logic [7:0]           con_data_out,
    output logic                 con_valid_out,
    input  logic                 con_ready_in,
    output logic [LED_WIDTH-1:0] led_out
);
    logic is_mmio, mmio_wr, con_push, con_full, con_empty, con_drop;
    logic [2:0] off;
    logic [LED_WIDTH-1:0] led_next;
    logic [31:0] mmio_rdata, hi_snap;
    logic [63:0] cycle_cnt;
    logic [7:0] dropped;
    mmio_rsp_t st1, st2;
    assign is_mmio = dmem_addr_in[31:16] == MMIO_BASE;
    assign off = dmem_addr_in[4:2];
    assign mmio_wr = is_mmio && |dmem_write_enable_in;
    assign ram_addr_out = dmem_addr_in;
    assign ram_data_out = dmem_data_in;
    assign ram_write_enable_out = is_mmio ? 4'b0 : dmem_write_enable_in;
    assign con_push = mmio_wr && off == MMIO_CON_TX && dmem_write_enable_in[0];
    assign con_drop = con_push && con_full && !(con_valid_out && con_ready_in);
    assign dmem_data_out = st2.is_mmio ? st2.rdata : ram_data_in;
    always_comb begin
        led_next = led_out;
        for (int b = 0; b < LED_WIDTH; b++)
            led_next[b] = dmem_write_enable_in[b / 8] ? dmem_data_in[b] : led_out[b];
    end
    always_comb begin
        mmio_rdata = off == MMIO_LED      ? 32'(led_out) :
                     off == MMIO_CON_TX   ? {30'b0, con_full, con_empty} :
                     off == MMIO_CYCLE_LO ? cycle_cnt[31:0] :
                     off == MMIO_CYCLE_HI ? hi_snap :
                     off == MMIO_DROPPED  ? {24'b0, dropped} : 32'b0;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            led_out <= '0;
            cycle_cnt <= '0;
            hi_snap <= '0;
            dropped <= '0;
            st1 <= '0;
            st2 <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            st1 <= {is_mmio, mmio_rdata};
            st2 <= st1;
            if (mmio_wr && off == MMIO_LED) led_out <= led_next;
            // snapshot the upper word so a LO-then-HI read pair is coherent
            if (is_mmio && !mmio_wr && off == MMIO_CYCLE_LO) hi_snap <= cycle_cnt[63:32];
            if (con_drop && dropped != 8'hFF) dropped <= dropped + 8'd1;
        end
    end
    console_fifo #(.DEPTH(CON_DEPTH)) u_fifo (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .push(con_push),
        .din(dmem_data_in[7:0]),
        .dout(con_data_out),
        .valid(con_valid_out),
        .ready(con_ready_in),
        .full(con_full),
        .empty(con_empty)
    );
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: randomized self-checking bench against a queue/array reference model
module tb_dmem_mmio_responder;
    localparam int DEPTH = 16;
    logic clk_in = 1'b0;
    logic rst_in;
    logic [31:0] dmem_addr_in, dmem_data_in, dmem_data_out, ram_addr_out, ram_data_out, ram_data_in;
    logic [3:0] dmem_write_enable_in, ram_write_enable_out;
    logic [7:0] con_data_out;
    logic con_valid_out, con_ready_in;
    logic [15:0] led_out;
    logic [31:0] r1, r2;
    int pass_cnt = 0, total_cnt = 0, edges = 0, rst_edge = 0, cap_edge = 0;
    logic [15:0] led_m;
    logic [7:0] q[$];
    int drop_m;

    dmem_mmio_responder #(.MMIO_BASE(16'h8000), .CON_DEPTH(DEPTH), .LED_WIDTH(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .dmem_addr_in(dmem_addr_in), .dmem_data_in(dmem_data_in),
        .dmem_write_enable_in(dmem_write_enable_in), .dmem_data_out(dmem_data_out),
        .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out),
        .ram_write_enable_out(ram_write_enable_out), .ram_data_in(ram_data_in),
        .con_data_out(con_data_out), .con_valid_out(con_valid_out),
        .con_ready_in(con_ready_in), .led_out(led_out)
    );

    always #5 clk_in = ~clk_in;

    // BRAM stand-in: two-cycle read of a fixed address-derived pattern
    always @(posedge clk_in) begin
        edges++;
        r1 <= ram_addr_out ^ 32'h5A5A0000;
        r2 <= r1;
    end
    assign ram_data_in = r2;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic idle();
        dmem_addr_in = 32'h0000_0100;
        dmem_data_in = 32'h0;
        dmem_write_enable_in = 4'b0;
    endtask

    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        dmem_addr_in = a;
        dmem_data_in = d;
        dmem_write_enable_in = we;
        @(negedge clk_in);
        idle();
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        dmem_addr_in = a;
        dmem_write_enable_in = 4'b0;
        @(negedge clk_in);
        cap_edge = edges;
        idle();
        @(negedge clk_in);
        d = dmem_data_out;
    endtask

    function automatic void push_model(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else if (drop_m < 255) drop_m++;
    endfunction

    function automatic logic [31:0] status_model();
        return {30'b0, q.size() == DEPTH, q.size() == 0};
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        rst_in = 1'b1;
        con_ready_in = 1'b0;
        idle();
        repeat (4) @(negedge clk_in);
        rst_in = 1'b0;
        rst_edge = edges;
        led_m = '0;
        q.delete();
        drop_m = 0;
        total_cnt++; if (led_out !== 16'h0) $display("FAIL reset_led got %h exp 0", led_out); else pass_cnt++;
        total_cnt++; if (con_valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", con_valid_out); else pass_cnt++;
        total_cnt++; if (con_data_out !== 8'h0) $display("FAIL reset_con_data got %h exp 0", con_data_out); else pass_cnt++;
        total_cnt++; if (dmem_data_out !== r2) $display("FAIL reset_ram_follow got %h exp %h", dmem_data_out, r2); else pass_cnt++;
        read_word(32'h8000_0000, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL reset_led_read got %h exp 0", d); else pass_cnt++;
        read_word(32'h8000_0004, d);
        total_cnt++; if (d !== 32'h1) $display("FAIL reset_status got %h exp 1", d); else pass_cnt++;
    endtask

    task automatic test_led();
        logic [31:0] d;
        logic [3:0] we;
        logic [15:0] mask;
        dmem_addr_in = 32'h8000_0000; dmem_data_in = 32'h0000_ABCD; dmem_write_enable_in = 4'b0001;
        #1;
        total_cnt++; if (ram_write_enable_out !== 4'b0) $display("FAIL led_ram_we0 got %b exp 0", ram_write_enable_out); else pass_cnt++;
        @(negedge clk_in);
        dmem_write_enable_in = 4'b0010;
        #1;
        total_cnt++; if (ram_write_enable_out !== 4'b0) $display("FAIL led_ram_we1 got %b exp 0", ram_write_enable_out); else pass_cnt++;
        @(negedge clk_in);
        idle();
        led_m = 16'hABCD;
        total_cnt++; if (led_out !== 16'hABCD) $display("FAIL led_merge got %h exp abcd", led_out); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            d = $urandom;
            we = 4'($urandom_range(0, 15));
            mask = (we[0] ? 16'h00FF : 16'h0) | (we[1] ? 16'hFF00 : 16'h0);
            if (we != 4'b0) led_m = (led_m & ~mask) | (d[15:0] & mask);
            mmio_write(32'h8000_0000 | 32'($urandom_range(0, 3)), d, we);
            total_cnt++; if (led_out !== led_m) $display("FAIL led_rand%0d got %h exp %h", i, led_out, led_m); else pass_cnt++;
        end
        read_word(32'h8000_0000, d);
        total_cnt++; if (d !== {16'h0, led_m}) $display("FAIL led_read got %h exp %h", d, {16'h0, led_m}); else pass_cnt++;
    endtask

    task automatic test_ram();
        logic [31:0] d;
        d = $urandom;
        dmem_addr_in = 32'h0000_0040; dmem_data_in = d; dmem_write_enable_in = 4'b1111;
        #1;
        total_cnt++; if (ram_addr_out !== 32'h40) $display("FAIL ram_addr got %h exp 40", ram_addr_out); else pass_cnt++;
        total_cnt++; if (ram_data_out !== d) $display("FAIL ram_data got %h exp %h", ram_data_out, d); else pass_cnt++;
        total_cnt++; if (ram_write_enable_out !== 4'b1111) $display("FAIL ram_we got %b exp 1111", ram_write_enable_out); else pass_cnt++;
        @(negedge clk_in);
        mmio_write(32'h8000_0014, 32'hFFFF_FFFF, 4'b1111);
        total_cnt++; if (led_out !== led_m) $display("FAIL unmapped_write got %h exp %h", led_out, led_m); else pass_cnt++;
        read_word(32'h0000_0040, d);
        total_cnt++; if (d !== (32'h40 ^ 32'h5A5A0000)) $display("FAIL ram_read got %h exp %h", d, 32'h40 ^ 32'h5A5A0000); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] a, e;
        int sel;
        for (int k = 0; k < 26; k++) begin
            if (k >= 2) begin
                e = exp_q.pop_front();
                total_cnt++; if (dmem_data_out !== e) $display("FAIL b2b%0d got %h exp %h", k, dmem_data_out, e); else pass_cnt++;
            end
            if (k < 24) begin
                sel = (k < 2) ? k : $urandom_range(0, 4);
                case (sel)
                    0: begin a = $urandom & 32'h7FFF_FFFC; e = a ^ 32'h5A5A0000; end
                    1: begin a = 32'h8000_0004; e = status_model(); end
                    2: begin a = 32'h8000_0000; e = {16'h0, led_m}; end
                    3: begin a = 32'h8000_0010; e = 32'(drop_m); end
                    default: begin a = 32'h8000_0014 + 32'(4 * $urandom_range(0, 2)); e = 32'h0; end
                endcase
                if (sel != 0) a = a | 32'($urandom_range(0, 3));
                dmem_addr_in = a;
                dmem_write_enable_in = 4'b0;
                exp_q.push_back(e);
            end else idle();
            @(negedge clk_in);
        end
    endtask

    task automatic test_console();
        logic [31:0] d;
        con_ready_in = 1'b0;
        mmio_write(32'h8000_0004, 32'h41, 4'b0001); push_model(8'h41);
        mmio_write(32'h8000_0004, 32'h42, 4'b0001); push_model(8'h42);
        mmio_write(32'h8000_0004, 32'h99, 4'b0010);
        total_cnt++; if (con_valid_out !== 1'b1) $display("FAIL con_valid got %b exp 1", con_valid_out); else pass_cnt++;
        total_cnt++; if (con_data_out !== q[0]) $display("FAIL con_head got %h exp %h", con_data_out, q[0]); else pass_cnt++;
        con_ready_in = 1'b1;
        while (q.size() > 0) begin
            total_cnt++; if (con_valid_out !== 1'b1 || con_data_out !== q[0]) $display("FAIL con_drain got %b/%h exp 1/%h", con_valid_out, con_data_out, q[0]); else pass_cnt++;
            void'(q.pop_front());
            @(negedge clk_in);
        end
        total_cnt++; if (con_valid_out !== 1'b0) $display("FAIL con_empty_valid got %b exp 0", con_valid_out); else pass_cnt++;
        dmem_addr_in = 32'h8000_0004; dmem_data_in = 32'h55; dmem_write_enable_in = 4'b0001;
        #1;
        total_cnt++; if (con_valid_out !== 1'b0) $display("FAIL con_pushpop_empty got %b exp 0", con_valid_out); else pass_cnt++;
        @(negedge clk_in);
        idle();
        total_cnt++; if (con_valid_out !== 1'b1 || con_data_out !== 8'h55) $display("FAIL con_next got %b/%h exp 1/55", con_valid_out, con_data_out); else pass_cnt++;
        @(negedge clk_in);
        con_ready_in = 1'b0;
        read_word(32'h8000_0004, d);
        total_cnt++; if (d !== status_model()) $display("FAIL con_status got %h exp %h", d, status_model()); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0] b;
        con_ready_in = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            b = 8'($urandom);
            push_model(b);
            mmio_write(32'h8000_0004, {24'($urandom), b}, 4'b0001);
        end
        read_word(32'h8000_0004, d);
        total_cnt++; if (d !== status_model()) $display("FAIL ovf_status got %h exp %h", d, status_model()); else pass_cnt++;
        read_word(32'h8000_0010, d);
        total_cnt++; if (d !== 32'(drop_m)) $display("FAIL ovf_dropped got %h exp %h", d, 32'(drop_m)); else pass_cnt++;
        b = 8'($urandom);
        con_ready_in = 1'b1;
        mmio_write(32'h8000_0004, {24'h0, b}, 4'b0001);
        con_ready_in = 1'b0;
        void'(q.pop_front());
        q.push_back(b);
        read_word(32'h8000_0010, d);
        total_cnt++; if (d !== 32'(drop_m)) $display("FAIL full_pushpop_dropped got %h exp %h", d, 32'(drop_m)); else pass_cnt++;
        read_word(32'h8000_0004, d);
        total_cnt++; if (d !== status_model()) $display("FAIL full_pushpop_status got %h exp %h", d, status_model()); else pass_cnt++;
        con_ready_in = 1'b1;
        while (q.size() > 0) begin
            total_cnt++; if (con_valid_out !== 1'b1 || con_data_out !== q[0]) $display("FAIL ovf_drain got %b/%h exp 1/%h", con_valid_out, con_data_out, q[0]); else pass_cnt++;
            void'(q.pop_front());
            @(negedge clk_in);
        end
        con_ready_in = 1'b0;
        total_cnt++; if (con_valid_out !== 1'b0) $display("FAIL ovf_drained got %b exp 0", con_valid_out); else pass_cnt++;
    endtask

    task automatic test_cycle();
        logic [31:0] lo1, lo2, hi;
        int c1;
        read_word(32'h8000_0008, lo1);
        c1 = cap_edge;
        total_cnt++; if (lo1 !== 32'(c1 - rst_edge - 1)) $display("FAIL cycle_lo got %h exp %h", lo1, 32'(c1 - rst_edge - 1)); else pass_cnt++;
        repeat (10) @(negedge clk_in);
        read_word(32'h8000_000C, hi);
        total_cnt++; if (hi !== 32'h0) $display("FAIL cycle_hi got %h exp 0", hi); else pass_cnt++;
        read_word(32'h8000_0008, lo2);
        total_cnt++; if (lo2 - lo1 !== 32'(cap_edge - c1)) $display("FAIL cycle_delta got %0d exp %0d", lo2 - lo1, cap_edge - c1); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        read_word(32'h8000_0008, d);
        total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL wrap_lo_max got %h exp ffffffff", d); else pass_cnt++;
        read_word(32'h8000_000C, d);
        total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL wrap_hi_max got %h exp ffffffff", d); else pass_cnt++;
        release dut.cycle_cnt;
        repeat (2) @(negedge clk_in);
        read_word(32'h8000_0008, d);
        total_cnt++; if (!(d < 32'd16)) $display("FAIL wrap_lo got %h exp below 10", d); else pass_cnt++;
        read_word(32'h8000_000C, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL wrap_hi got %h exp 0", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        con_ready_in = 1'b0;
        mmio_write(32'h8000_0000, 32'h0000_1234, 4'b0011);
        for (int i = 0; i < 3; i++) mmio_write(32'h8000_0004, 32'($urandom), 4'b0001);
        dmem_addr_in = 32'h8000_0000; dmem_write_enable_in = 4'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        dmem_addr_in = 32'h8000_0000; dmem_data_in = 32'hFFFF_FFFF; dmem_write_enable_in = 4'b1111;
        @(negedge clk_in);
        rst_in = 1'b0;
        rst_edge = edges;
        idle();
        led_m = '0;
        q.delete();
        drop_m = 0;
        total_cnt++; if (led_out !== 16'h0) $display("FAIL mid_led got %h exp 0", led_out); else pass_cnt++;
        total_cnt++; if (con_valid_out !== 1'b0) $display("FAIL mid_valid got %b exp 0", con_valid_out); else pass_cnt++;
        total_cnt++; if (dmem_data_out !== r2) $display("FAIL mid_flush got %h exp %h", dmem_data_out, r2); else pass_cnt++;
        read_word(32'h8000_0004, d);
        total_cnt++; if (d !== 32'h1) $display("FAIL mid_status got %h exp 1", d); else pass_cnt++;
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        con_ready_in = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_led();
        test_ram();
        test_back_to_back();
        test_console();
        test_overflow();
        test_cycle();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
